// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the Datapath command sequencer: opcodes, function
// selects, FSM state encoding and control-word field widths.
package datapath_ctrl_pkg;

    localparam int unsigned OP_W     = 2;
    localparam int unsigned FS_W     = 5;
    localparam int unsigned STATUS_W = 4;

    localparam logic [OP_W-1:0] OP_LOADI  = 2'b00;
    localparam logic [OP_W-1:0] OP_ALU_RR = 2'b01;
    localparam logic [OP_W-1:0] OP_ALU_RI = 2'b10;
    localparam logic [OP_W-1:0] OP_CLEAR  = 2'b11;

    localparam logic [FS_W-1:0] FS_ADD = 5'b01000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WRITE,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/datapath_sequencer.sv
// Command-driven sequencer for the register-file/ALU Datapath. Each accepted
// command is expanded into registered per-cycle control words; completion is
// flagged by a one-cycle done pulse with the ALU status of the final write.
module datapath_sequencer
    import datapath_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [OP_W-1:0]     cmd_op,
    input  logic [FS_W-1:0]     cmd_fs,
    input  logic                cmd_cin,
    input  logic [ADDR_W-1:0]   cmd_sa,
    input  logic [ADDR_W-1:0]   cmd_sb,
    input  logic [ADDR_W-1:0]   cmd_da,
    input  logic [DATA_W-1:0]   cmd_k,
    input  logic [STATUS_W-1:0] status,
    output logic [ADDR_W-1:0]   SA,
    output logic [ADDR_W-1:0]   SB,
    output logic [ADDR_W-1:0]   DA,
    output logic                W,
    output logic [DATA_W-1:0]   K,
    output logic [FS_W-1:0]     FS,
    output logic                C_in,
    output logic                B_SEL,
    output logic                EN_ALU,
    output logic                EN_B,
    output logic                busy,
    output logic                done,
    output logic [STATUS_W-1:0] status_out
);

    localparam logic [ADDR_W-1:0] ZERO_REG  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] LAST_CLR  = ADDR_W'(NUM_REGS - 2);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic [OP_W-1:0]     op_q;
    logic [FS_W-1:0]     fs_q;
    logic                cin_q;
    logic [ADDR_W-1:0]   sa_q, sb_q, da_q;
    logic [DATA_W-1:0]   k_q;

    logic                accept;
    logic                last_clear;
    logic                capture;

    logic [OP_W-1:0]     src_op;
    logic [FS_W-1:0]     src_fs;
    logic                src_cin;
    logic [ADDR_W-1:0]   src_sa, src_sb, src_da;
    logic [DATA_W-1:0]   src_k;

    logic [ADDR_W-1:0]   sa_d, sb_d, da_d;
    logic                w_d, cin_d, bsel_d, en_alu_d, busy_d, done_d;
    logic [DATA_W-1:0]   k_d;
    logic [FS_W-1:0]     fs_d;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign accept     = cmd_valid & cmd_ready;
    assign last_clear = (state_q == ST_CLEAR) && (cnt_q == LAST_CLR);
    assign capture    = (state_q == ST_WRITE) || last_clear;

    // Outputs are registered, so the word for the cycle after a handshake is
    // built from the live cmd_* inputs; afterwards only the latched copy is used.
    assign src_op  = (state_q == ST_IDLE) ? cmd_op  : op_q;
    assign src_fs  = (state_q == ST_IDLE) ? cmd_fs  : fs_q;
    assign src_cin = (state_q == ST_IDLE) ? cmd_cin : cin_q;
    assign src_sa  = (state_q == ST_IDLE) ? cmd_sa  : sa_q;
    assign src_sb  = (state_q == ST_IDLE) ? cmd_sb  : sb_q;
    assign src_da  = (state_q == ST_IDLE) ? cmd_da  : da_q;
    assign src_k   = (state_q == ST_IDLE) ? cmd_k   : k_q;

    // State register, clear counter and command latch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            fs_q    <= '0;
            cin_q   <= 1'b0;
            sa_q    <= '0;
            sb_q    <= '0;
            da_q    <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q  <= cmd_op;
                fs_q  <= cmd_fs;
                cin_q <= cmd_cin;
                sa_q  <= cmd_sa;
                sb_q  <= cmd_sb;
                da_q  <= cmd_da;
                k_q   <= cmd_k;
            end
        end
    end

    // Next state and the control word to present during that state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sa_d     = ZERO_REG;
        sb_d     = '0;
        da_d     = '0;
        w_d      = 1'b0;
        k_d      = '0;
        fs_d     = '0;
        cin_d    = 1'b0;
        bsel_d   = 1'b0;
        en_alu_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = capture;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (cmd_op == OP_CLEAR) ? ST_CLEAR : ST_ISSUE;
                    cnt_d   = '0;
                end
            end
            ST_ISSUE: state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            ST_CLEAR: begin
                if (last_clear) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_ISSUE, ST_WRITE: begin
                en_alu_d = 1'b1;
                busy_d   = 1'b1;
                case (src_op)
                    OP_LOADI: begin
                        bsel_d = 1'b1;
                        k_d    = src_k;
                        fs_d   = FS_ADD;
                    end
                    OP_ALU_RR: begin
                        sa_d  = src_sa;
                        sb_d  = src_sb;
                        fs_d  = src_fs;
                        cin_d = src_cin;
                    end
                    OP_ALU_RI: begin
                        sa_d   = src_sa;
                        bsel_d = 1'b1;
                        k_d    = src_k;
                        fs_d   = src_fs;
                        cin_d  = src_cin;
                    end
                    default: ;
                endcase
                if (state_d == ST_WRITE) begin
                    da_d = src_da;
                    w_d  = (src_da != ZERO_REG);
                end
            end
            ST_CLEAR: begin
                bsel_d   = 1'b1;
                fs_d     = FS_ADD;
                en_alu_d = 1'b1;
                w_d      = 1'b1;
                da_d     = cnt_d;
                busy_d   = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered control word, completion pulse and captured ALU status.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            SA         <= ZERO_REG;
            SB         <= '0;
            DA         <= '0;
            W          <= 1'b0;
            K          <= '0;
            FS         <= '0;
            C_in       <= 1'b0;
            B_SEL      <= 1'b0;
            EN_ALU     <= 1'b0;
            EN_B       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            status_out <= '0;
        end else begin
            SA     <= sa_d;
            SB     <= sb_d;
            DA     <= da_d;
            W      <= w_d;
            K      <= k_d;
            FS     <= fs_d;
            C_in   <= cin_d;
            B_SEL  <= bsel_d;
            EN_ALU <= en_alu_d;
            EN_B   <= 1'b0;
            busy   <= busy_d;
            done   <= done_d;
            if (capture) begin
                status_out <= status;
            end
        end
    end

endmodule
